// File: rtl/magia_tile_boot_ctrl_pkg.sv
// Shared boot-control definitions: FSM state encoding, register word indices and CTRL/STATUS
// bit positions, kept in step with the runtime headers.
package magia_pkg;

    typedef enum logic [1:0] {
        BOOT_IDLE   = 2'd0,
        BOOT_SETTLE = 2'd1,
        BOOT_RUN    = 2'd2,
        BOOT_DRAIN  = 2'd3
    } boot_state_e;

    localparam logic [2:0] BOOT_CTRL_IDX   = 3'd0;
    localparam logic [2:0] BOOT_ADDR_IDX   = 3'd1;
    localparam logic [2:0] BOOT_STATUS_IDX = 3'd2;
    localparam logic [2:0] BOOT_WAKE_IDX   = 3'd3;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_STOP_BIT  = 1;
    localparam int unsigned STATUS_TO_BIT  = 3;

endpackage

// File: rtl/magia_tile_boot_ctrl_if.sv
// Host register bus for the tile boot controller: request/grant with a one-cycle response.
interface magia_tile_boot_ctrl_if;

    logic        cfg_req;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_gnt;
    logic        cfg_rvalid;
    logic [31:0] cfg_rdata;

    modport master (
        output cfg_req, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_gnt, cfg_rvalid, cfg_rdata
    );

    modport slave (
        input  cfg_req, cfg_we, cfg_addr, cfg_wdata,
        output cfg_gnt, cfg_rvalid, cfg_rdata
    );

endinterface

// File: rtl/magia_tile_boot_ctrl.sv
// Per-tile boot controller: sequences enable/settle/fetch, orderly drain-to-sleep stop,
// and turns queued host wake requests into single-cycle wu_wfe pulses.
module magia_tile_boot_ctrl
    import magia_pkg::*;
#(
    parameter int unsigned ENABLE_DLY    = 4,
    parameter int unsigned WAKE_CNT_W    = 4,
    parameter int unsigned DRAIN_TO_W    = 16,
    parameter logic [31:0] BOOT_ADDR_RST = 32'h0000_1000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    magia_tile_boot_ctrl_if.slave         cfg,
    output logic                          tile_enable_o,
    output logic                          fetch_enable_o,
    output logic [31:0]                   boot_addr_o,
    output logic                          wu_wfe_o,
    input  logic                          core_sleep_i
);

    localparam int unsigned           DLY_W    = (ENABLE_DLY > 1) ? $clog2(ENABLE_DLY) : 1;
    localparam logic [DLY_W-1:0]      DLY_LOAD = DLY_W'(ENABLE_DLY - 1);
    localparam logic [WAKE_CNT_W-1:0] WAKE_MAX = '1;
    localparam logic [DRAIN_TO_W-1:0] TO_MAX   = '1;

    boot_state_e             r_state;
    boot_state_e             w_state_nxt;
    logic [DLY_W-1:0]        r_dly;
    logic [DRAIN_TO_W-1:0]   r_to_cnt;
    logic [WAKE_CNT_W-1:0]   r_pending;
    logic                    r_drain_to;
    logic                    r_tile_en;
    logic                    r_fetch_en;
    logic                    r_wu_wfe;
    logic [31:0]             r_boot_addr;
    logic                    r_rvalid;
    logic [31:0]             r_rdata;

    logic [2:0]              w_idx;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_start;
    logic                    w_stop;
    logic                    w_wake_wr;
    logic                    w_boot_wr;
    logic                    w_to_clr;
    logic                    w_to_hit;
    logic                    w_deliver;
    logic                    w_enter_idle;
    logic [31:0]             w_status;
    logic [31:0]             w_rdata;
    logic                    w_unused;

    assign w_idx     = cfg.cfg_addr[4:2];
    assign w_wr      = cfg.cfg_req &  cfg.cfg_we;
    assign w_rd      = cfg.cfg_req & ~cfg.cfg_we;
    assign w_unused  = ^cfg.cfg_addr[1:0];

    // STOP dominates START when both are written together
    assign w_stop    = w_wr && (w_idx == BOOT_CTRL_IDX) && cfg.cfg_wdata[CTRL_STOP_BIT];
    assign w_start   = w_wr && (w_idx == BOOT_CTRL_IDX) && cfg.cfg_wdata[CTRL_START_BIT]
                       && !cfg.cfg_wdata[CTRL_STOP_BIT];
    assign w_wake_wr = w_wr && (w_idx == BOOT_WAKE_IDX);
    assign w_boot_wr = w_wr && (w_idx == BOOT_ADDR_IDX) && (r_state == BOOT_IDLE);
    assign w_to_clr  = w_wr && (w_idx == BOOT_STATUS_IDX) && cfg.cfg_wdata[STATUS_TO_BIT];

    assign w_to_hit     = (r_state == BOOT_DRAIN) && !core_sleep_i && (r_to_cnt == TO_MAX);
    assign w_deliver    = ((r_state == BOOT_RUN) || (r_state == BOOT_DRAIN)) && core_sleep_i
                          && (r_pending != '0) && !r_wu_wfe;
    assign w_enter_idle = (w_state_nxt == BOOT_IDLE) && (r_state != BOOT_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            BOOT_IDLE:   if (w_start) w_state_nxt = BOOT_SETTLE;
            BOOT_SETTLE: begin
                if (w_stop)              w_state_nxt = BOOT_IDLE;
                else if (r_dly == '0)    w_state_nxt = BOOT_RUN;
            end
            BOOT_RUN:    if (w_stop) w_state_nxt = BOOT_DRAIN;
            BOOT_DRAIN:  if (core_sleep_i || (r_to_cnt == TO_MAX)) w_state_nxt = BOOT_IDLE;
            default:     w_state_nxt = BOOT_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= BOOT_IDLE;
        else       r_state <= w_state_nxt;
    end

    assign w_status = {16'h0, 8'(r_pending), 4'h0, r_drain_to, core_sleep_i, r_state};

    always_comb begin
        w_rdata = '0;
        unique case (w_idx)
            BOOT_ADDR_IDX:   w_rdata = r_boot_addr;
            BOOT_STATUS_IDX: w_rdata = w_status;
            BOOT_WAKE_IDX:   w_rdata = 32'(r_pending);
            default:         w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dly       <= DLY_LOAD;
            r_to_cnt    <= '0;
            r_pending   <= '0;
            r_drain_to  <= 1'b0;
            r_tile_en   <= 1'b0;
            r_fetch_en  <= 1'b0;
            r_wu_wfe    <= 1'b0;
            r_boot_addr <= BOOT_ADDR_RST;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
        end else begin
            // Counter reloads while idle so SETTLE always starts from ENABLE_DLY-1
            if (r_state == BOOT_IDLE)                        r_dly <= DLY_LOAD;
            else if ((r_state == BOOT_SETTLE) && (r_dly != '0)) r_dly <= r_dly - 1'b1;

            if (r_state != BOOT_DRAIN)    r_to_cnt <= '0;
            else if (r_to_cnt != TO_MAX)  r_to_cnt <= r_to_cnt + 1'b1;

            r_tile_en  <= (w_state_nxt != BOOT_IDLE);
            r_fetch_en <= (w_state_nxt == BOOT_RUN);
            r_wu_wfe   <= w_deliver;

            if (w_enter_idle)                                   r_pending <= '0;
            else if (w_wake_wr && !w_deliver && (r_pending != WAKE_MAX)) r_pending <= r_pending + 1'b1;
            else if (w_deliver && !w_wake_wr)                   r_pending <= r_pending - 1'b1;

            if (w_to_hit)      r_drain_to <= 1'b1;
            else if (w_to_clr) r_drain_to <= 1'b0;

            if (w_boot_wr) r_boot_addr <= cfg.cfg_wdata;

            r_rvalid <= cfg.cfg_req;
            r_rdata  <= w_rd ? w_rdata : '0;
        end
    end

    assign cfg.cfg_gnt    = cfg.cfg_req;
    assign cfg.cfg_rvalid = r_rvalid;
    assign cfg.cfg_rdata  = r_rdata;
    assign tile_enable_o  = r_tile_en;
    assign fetch_enable_o = r_fetch_en;
    assign boot_addr_o    = r_boot_addr;
    assign wu_wfe_o       = r_wu_wfe;

endmodule

// File: tb/tb_magia_tile_boot_ctrl.sv
// Self-checking bench for magia_tile_boot_ctrl: directed sequence plus randomized register
// traffic checked against a transaction-level model of the controller.
module tb_magia_tile_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sleep = 1'b0;
    logic        tile_en, fetch_en, wu;
    logic [31:0] boot_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model of architectural state, updated per host transaction
    int          m_state = 0;
    int          m_pend  = 0;
    bit          m_to    = 1'b0;
    logic [31:0] m_boot  = 32'h0000_1000;

    magia_tile_boot_ctrl_if u_if ();

    magia_tile_boot_ctrl #(
        .ENABLE_DLY    (4),
        .WAKE_CNT_W    (4),
        .DRAIN_TO_W    (16),
        .BOOT_ADDR_RST (32'h0000_1000)
    ) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cfg            (u_if),
        .tile_enable_o  (tile_en),
        .fetch_enable_o (fetch_en),
        .boot_addr_o    (boot_addr),
        .wu_wfe_o       (wu),
        .core_sleep_i   (sleep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int idx);
        case (idx)
            1:       return m_boot;
            2:       return {16'h0, 8'(m_pend), 4'h0, m_to, sleep, 2'(m_state)};
            3:       return 32'(m_pend);
            default: return 32'h0;
        endcase
    endfunction

    task automatic xfer(input bit we, input logic [4:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
        u_if.cfg_req   = 1'b1;
        u_if.cfg_we    = we;
        u_if.cfg_addr  = addr;
        u_if.cfg_wdata = wd;
        #1;
        check("gnt", 32'(u_if.cfg_gnt), 32'd1);
        @(posedge clk);
        #1;
        u_if.cfg_req = 1'b0;
        u_if.cfg_we  = 1'b0;
        check("rvalid", 32'(u_if.cfg_rvalid), 32'd1);
        rd = u_if.cfg_rdata;
        if (we) check("wr_rdata_zero", rd, 32'h0);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        xfer(1'b1, addr, wd, rd);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        xfer(1'b0, addr, 32'h0, rd);
        check(tag, rd, exp);
    endtask

    task automatic wake_wr();
        wr(5'h0C, $urandom);
        m_pend = (m_pend < 15) ? m_pend + 1 : 15;
    endtask

    task automatic wait_fetch(output int cyc);
        cyc = 0;
        while (!fetch_en && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int          cyc;
        int          pulses;
        int          adj;
        int          expect_pulses;
        bit          prev;
        logic [31:0] val;

        u_if.cfg_req   = 1'b0;
        u_if.cfg_we    = 1'b0;
        u_if.cfg_addr  = '0;
        u_if.cfg_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tile_en", 32'(tile_en), 32'd0);
        check("rst_fetch",   32'(fetch_en), 32'd0);
        check("rst_wu",      32'(wu), 32'd0);
        check("rst_boot",    boot_addr, 32'h0000_1000);
        check("rst_rvalid",  32'(u_if.cfg_rvalid), 32'd0);
        check("rst_rdata",   u_if.cfg_rdata, 32'h0);
        rst = 1'b0;

        rd_chk("rd_boot_rst",   5'h04, m_read(1));
        rd_chk("rd_status_rst", 5'h08, 32'h0);

        // Boot address and start sequence
        wr(5'h04, 32'hCC00_0080);
        m_boot = 32'hCC00_0080;
        check("boot_idle_wr", boot_addr, m_boot);
        wr(5'h00, 32'h1);
        m_state = 1;
        check("start_en",    32'(tile_en), 32'd1);
        check("start_fetch", 32'(fetch_en), 32'd0);
        wait_fetch(cyc);
        check("enable_dly", 32'(cyc), 32'd4);
        m_state = 2;
        rd_chk("status_run", 5'h08, m_read(2));

        // Randomized traffic in RUN with the core awake
        for (int i = 0; i < 40; i++) begin
            int op;
            int a;
            op = $urandom_range(0, 3);
            case (op)
                0: wake_wr();
                1: wr(5'h04, $urandom);
                2: begin
                    a = $urandom_range(0, 7);
                    rd_chk("rand_rd", 5'(a * 4 + $urandom_range(0, 3)), m_read(a));
                end
                default: wr(5'h00, 32'h1);
            endcase
            check("rand_wu",    32'(wu), 32'd0);
            check("rand_fetch", 32'(fetch_en), 32'd1);
            check("rand_boot",  boot_addr, m_boot);
        end
        rd_chk("rand_pending", 5'h0C, m_read(3));

        // Core sleeps: every pending wake delivered as an isolated pulse
        expect_pulses = m_pend;
        sleep  = 1'b1;
        pulses = 0;
        adj    = 0;
        prev   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (wu) pulses++;
            if (wu && prev) adj++;
            prev = wu;
        end
        m_pend = 0;
        check("wake_pulses",   32'(pulses), 32'(expect_pulses));
        check("wake_adjacent", 32'(adj), 32'd0);
        rd_chk("wake_drained", 5'h08, m_read(2));
        sleep = 1'b0;

        // Saturation
        for (int i = 0; i < 20; i++) wake_wr();
        rd_chk("wake_sat", 5'h0C, 32'd15);
        check("wake_sat_model", 32'(m_pend), 32'd15);

        // START|STOP in RUN -> DRAIN, then timeout with core awake
        wr(5'h00, 32'h3);
        m_state = 3;
        check("drain_en",    32'(tile_en), 32'd1);
        check("drain_fetch", 32'(fetch_en), 32'd0);
        rd_chk("drain_status", 5'h08, m_read(2));
        cyc = 0;
        while (tile_en && cyc < 70000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_timeout_window", 32'(cyc >= 65530 && cyc <= 65540), 32'd1);
        m_state = 0;
        m_pend  = 0;
        m_to    = 1'b1;
        rd_chk("timeout_status", 5'h08, m_read(2));
        wr(5'h08, 32'h8);
        m_to = 1'b0;
        rd_chk("timeout_cleared", 5'h08, m_read(2));

        // Control writes that must be ignored in IDLE
        wr(5'h00, 32'h3);
        wr(5'h00, 32'h2);
        @(posedge clk);
        #1;
        check("idle_ignore_en", 32'(tile_en), 32'd0);

        // STOP during SETTLE aborts straight to IDLE
        val = $urandom;
        m_boot = {val[31:4], 4'h4};
        wr(5'h04, m_boot);
        check("boot_idle_wr2", boot_addr, m_boot);
        wr(5'h00, 32'h1);
        wr(5'h00, 32'h2);
        check("settle_stop_en", 32'(tile_en), 32'd0);
        rd_chk("settle_stop_status", 5'h08, m_read(2));

        // DRAIN exits immediately once the core sleeps
        wr(5'h00, 32'h1);
        wait_fetch(cyc);
        check("restart_fetch", 32'(fetch_en), 32'd1);
        wake_wr();
        wake_wr();
        wr(5'h00, 32'h2);
        sleep = 1'b1;
        @(posedge clk);
        #1;
        check("drain_sleep_en", 32'(tile_en), 32'd0);
        m_pend = 0;
        rd_chk("drain_sleep_status", 5'h08, m_read(2));
        sleep = 1'b0;

        // Reset during SETTLE
        wr(5'h00, 32'h1);
        @(posedge clk);
        #1;
        check("settle_en", 32'(tile_en), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_state = 0;
        m_boot  = 32'h0000_1000;
        check("midrst_en",     32'(tile_en), 32'd0);
        check("midrst_fetch",  32'(fetch_en), 32'd0);
        check("midrst_wu",     32'(wu), 32'd0);
        check("midrst_boot",   boot_addr, m_boot);
        check("midrst_rvalid", 32'(u_if.cfg_rvalid), 32'd0);
        rd_chk("midrst_status", 5'h08, m_read(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
